// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment pattern table and scan-FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } seg7_state_e;

    // Entry k is the a..g pattern (bit6=a) that displays hex nibble k.
    localparam logic [15:0][6:0] c_SEG7_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        return c_SEG7_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational reverse lookup of a segment pattern to a nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       hit_o
);

    always_comb begin
        nibble_o = 4'd0;
        hit_o    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (pattern_i == c_SEG7_TABLE[k]) begin
                nibble_o = 4'(k);
                hit_o    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Recovers a hex value from a scanned, multiplexed 7-seg display.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             segment,
    input  logic [NDIGITS-1:0]     digit_sel,
    output logic [4*NDIGITS-1:0]   value,
    output logic                   valid,
    output logic                   error,
    output logic [NDIGITS-1:0]     digit_err
);

    // cnt counts matching comparisons, so STABLE_CYCLES samples need one fewer.
    localparam logic [7:0]         c_CAPTURE_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [NDIGITS-1:0] c_SEL_ONE     = NDIGITS'(1);

    logic [6:0]           seg_q, seg_prev_q;
    logic [NDIGITS-1:0]   sel_q, sel_prev_q;
    seg7_state_e          state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [NDIGITS-1:0]   captured_q, captured_d;
    logic [4*NDIGITS-1:0] shadow_q, shadow_d;
    logic [NDIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*NDIGITS-1:0] value_q;
    logic                 valid_q, error_q;
    logic [NDIGITS-1:0]   digit_err_q;

    logic                 w_unchanged, w_onehot, w_capture, w_frame_done;
    logic [7:0]           w_cnt_inc;
    logic [3:0]           w_nibble;
    logic                 w_hit;

    seg7_pattern_decode u_decode (
        .pattern_i (seg_q),
        .nibble_o  (w_nibble),
        .hit_o     (w_hit)
    );

    assign w_unchanged = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
    assign w_onehot    = (sel_q != '0) && ((sel_q & (sel_q - c_SEL_ONE)) == '0);
    assign w_cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (w_onehot) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (w_unchanged) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_CAPTURE_CNT) begin
                        w_capture = 1'b1;
                        state_d   = ST_HELD;
                    end
                end else begin
                    cnt_d   = 8'd0;
                    state_d = w_onehot ? ST_SETTLE : ST_WAIT;
                end
            end
            ST_HELD: begin
                if (w_unchanged) begin
                    cnt_d = w_cnt_inc;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = w_onehot ? ST_SETTLE : ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        captured_d   = captured_q;
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        w_frame_done = 1'b0;
        if (w_capture) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if (sel_q[i]) begin
                    shadow_d[4*i +: 4] = w_hit ? w_nibble : 4'd0;
                    shadow_err_d[i]    = ~w_hit;
                end
            end
            captured_d   = captured_q | sel_q;
            w_frame_done = &captured_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q        <= '0;
            sel_q        <= '0;
            seg_prev_q   <= '0;
            sel_prev_q   <= '0;
            state_q      <= ST_WAIT;
            cnt_q        <= 8'd0;
            captured_q   <= '0;
            shadow_q     <= '0;
            shadow_err_q <= '0;
            value_q      <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            digit_err_q  <= '0;
        end else begin
            seg_q      <= segment;
            sel_q      <= digit_sel;
            seg_prev_q <= seg_q;
            sel_prev_q <= sel_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            valid_q    <= w_frame_done;
            if (w_frame_done) begin
                value_q      <= shadow_d;
                digit_err_q  <= shadow_err_d;
                error_q      <= |shadow_err_d;
                captured_q   <= '0;
                shadow_err_q <= '0;
            end else begin
                captured_q   <= captured_d;
                shadow_err_q <= shadow_err_d;
            end
        end
    end

    assign value     = value_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign digit_err = digit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Self-checking bench with a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int ST = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      segment;
    logic [ND-1:0]   digit_sel;
    logic [4*ND-1:0] value;
    logic            valid;
    logic            error;
    logic [ND-1:0]   digit_err;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NDIGITS(ND), .STABLE_CYCLES(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .segment   (segment),
        .digit_sel (digit_sel),
        .value     (value),
        .valid     (valid),
        .error     (error),
        .digit_err (digit_err)
    );

    int n_pass = 0, n_total = 0, cyc = 0, vcount = 0, valid_cyc = 0, last_start = 0;
    bit check_en = 1'b0;

    function automatic logic [6:0] pat_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference model: a digit is accepted once a run of ST identical
    // (segment, digit_sel) samples is complete; the capture lands one edge later.
    int              run;
    logic [6:0]      last_seg;
    logic [ND-1:0]   last_sel;
    logic [ND-1:0]   m_cap, m_serr, m_derr;
    logic [4*ND-1:0] m_shadow, m_value;
    logic            m_valid, m_error;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            run = 1; last_seg = '0; last_sel = '0;
            m_cap = '0; m_serr = '0; m_shadow = '0;
            m_value = '0; m_derr = '0; m_error = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (run == ST && $onehot(last_sel)) begin
                int idx; int nib; bit found;
                idx = 0; nib = 0; found = 1'b0;
                for (int k = 0; k < ND; k++) if (last_sel[k]) idx = k;
                for (int k = 0; k < 16; k++) if (pat_of(4'(k)) == last_seg) begin nib = k; found = 1'b1; end
                m_shadow[4*idx +: 4] = found ? 4'(nib) : 4'd0;
                m_serr[idx] = !found;
                m_cap[idx]  = 1'b1;
                if (&m_cap) begin
                    m_value = m_shadow; m_derr = m_serr; m_error = |m_serr;
                    m_valid = 1'b1; m_cap = '0; m_serr = '0;
                end
            end
            if (segment == last_seg && digit_sel == last_sel) run++;
            else begin run = 1; last_seg = segment; last_sel = digit_sel; end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("value", 32'(value), 32'(m_value));
            check("valid", 32'(valid), 32'(m_valid));
            check("err_flags", 32'({error, digit_err}), 32'({m_error, m_derr}));
            if (valid) begin vcount++; valid_cyc = cyc; end
        end
    end

    task automatic drive(input logic [6:0] s, input logic [ND-1:0] d, input int n);
        segment = s; digit_sel = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
    endtask

    task automatic scan(input logic [15:0] v, input logic [ND-1:0] mask, input int bad);
        for (int i = 0; i < ND; i++) begin
            if (mask[i]) begin
                last_start = cyc;
                drive((i == bad) ? 7'h00 : pat_of(v[4*i +: 4]), ND'(1) << i, 8);
            end
        end
        drive(7'h00, '0, 4);
    endtask

    initial begin
        reset = 1'b1; segment = '0; digit_sel = '0;
        repeat (2) @(negedge clk);
        check("reset_value", 32'(value), 32'h0);
        check("reset_flags", 32'({valid, error, digit_err}), 32'h0);
        reset = 1'b0; check_en = 1'b1;

        // Clean scan of 0x1A3F with latency measurement on the last digit.
        vcount = 0;
        scan(16'h1A3F, 4'hF, -1);
        check("scan1_pulses", 32'(vcount), 32'd1);
        check("scan1_value", 32'(value), 32'h1A3F);
        check("scan1_error", 32'({error, digit_err}), 32'h0);
        check("scan1_latency", 32'(valid_cyc - last_start), 32'(ST + 1));

        // Too-short dwell must not capture digit 0.
        vcount = 0;
        drive(7'h7E, 4'b0001, 3);
        drive(7'h00, '0, 10);
        check("glitch_no_valid", 32'(vcount), 32'd0);
        scan(16'h1A3F, 4'b1110, -1);
        check("glitch_no_capture", 32'(vcount), 32'd0);
        do_reset();
        @(negedge clk);
        check("reset_clears_value", 32'(value), 32'h0);

        // Blank pattern on digit 2 is undecodable.
        vcount = 0;
        scan(16'h5678, 4'hF, 2);
        check("blank_pulses", 32'(vcount), 32'd1);
        check("blank_digit_err", 32'(digit_err), 32'b0100);
        check("blank_error", 32'(error), 32'd1);
        check("blank_value", 32'(value), 32'h5078);

        // Multi-hot strobe is ignored.
        vcount = 0;
        drive(7'h7E, 4'b0011, 20);
        drive(7'h00, '0, 2);
        scan(16'hBEEF, 4'b1100, -1);
        check("multihot_no_capture", 32'(vcount), 32'd0);
        scan(16'hBEEF, 4'hF, -1);
        check("beef_pulses", 32'(vcount), 32'd1);
        check("beef_value", 32'(value), 32'hBEEF);

        // Reset mid-frame discards partial captures.
        do_reset();
        vcount = 0;
        scan(16'h0042, 4'b0011, -1);
        do_reset();
        scan(16'h0042, 4'b1100, -1);
        check("reset_discard", 32'(vcount), 32'd0);
        scan(16'h0042, 4'hF, -1);
        check("after_reset_pulses", 32'(vcount), 32'd1);
        check("after_reset_value", 32'(value), 32'h0042);

        // Re-capture of digit 1 within a frame: latest wins.
        do_reset();
        vcount = 0;
        drive(pat_of(4'h7), 4'b0001, 8);
        drive(7'h30, 4'b0010, 8);
        drive(7'h6D, 4'b0010, 8);
        drive(pat_of(4'h4), 4'b0100, 8);
        drive(pat_of(4'hC), 4'b1000, 8);
        drive(7'h00, '0, 4);
        check("recap_pulses", 32'(vcount), 32'd1);
        check("recap_value", 32'(value), 32'hC427);

        // Randomized dwells, strobes, patterns and occasional resets.
        do_reset();
        vcount = 0;
        repeat (400) begin
            int r;
            logic [6:0] s;
            logic [ND-1:0] d;
            r = $urandom_range(0, 9);
            if (r < 7)       d = ND'(1) << $urandom_range(0, ND - 1);
            else if (r == 7) d = '0;
            else             d = ND'($urandom);
            if ($urandom_range(0, 9) < 8) s = pat_of(4'($urandom_range(0, 15)));
            else                          s = 7'($urandom);
            if ($urandom_range(0, 49) == 0) do_reset();
            drive(s, d, $urandom_range(1, 9));
        end
        drive(7'h00, '0, 4);
        check("random_activity", 32'(vcount > 0), 32'd1);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 4, giving the number of scanned digits, legal range 1..8.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical samples needed to accept a digit, legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port segment, input, 7 bits, active-high segment pattern with bit6=a through bit0=g.
REQ-006 The block SHALL have port digit_sel, input, NDIGITS bits, active-high one-hot digit strobe; bit i selects nibble i, and bit 0 is least significant.
REQ-007 The block SHALL have port value, output, 4*NDIGITS bits, the last completed frame.
REQ-008 The block SHALL have port valid, output, 1 bit, a one-cycle pulse on each value update.
REQ-009 The block SHALL have port error, output, 1 bit, high when any digit in the last frame was undecodable.
REQ-010 The block SHALL have port digit_err, output, NDIGITS bits, per-digit undecodable flags for the last frame.

Function
REQ-011 The block SHALL register segment and digit_sel once, and all decisions use the registered copies.
REQ-012 The decode table SHALL be 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=B, 4E=C, 3D=D, 4F=E, 47=F (hex pattern=nibble); any other pattern, including 00, SHALL be undecodable.
REQ-013 The control FSM SHALL have states WAIT, SETTLE and HELD.
REQ-014 In WAIT, the block SHALL stay while registered digit_sel is zero or multi-hot, and SHALL go to SETTLE with cnt=0 on a one-hot value.
REQ-015 In SETTLE, if the registered segment and digit_sel equal the previous cycle's, cnt SHALL increment; otherwise cnt SHALL clear, staying in SETTLE if one-hot and going to WAIT if not.
REQ-016 In SETTLE, when cnt==STABLE_CYCLES-1 and the inputs are unchanged, the block SHALL capture at the next edge and go to HELD.
REQ-017 In HELD, the block SHALL stay while the inputs are unchanged, and on any change SHALL behave as on leaving WAIT; each dwell SHALL yield at most one capture.
REQ-018 A capture SHALL write the decoded nibble (or 0 if undecodable) to shadow slot i, set captured[i], and set or clear shadow_err[i].
REQ-019 A re-capture of a digit before its frame completes SHALL overwrite that slot, latest wins.
REQ-020 When a capture makes captured all-ones, on that same edge value SHALL load the shadow including the new nibble, digit_err SHALL load shadow_err, error SHALL equal the OR of shadow_err, valid SHALL be 1 for one cycle, and captured and shadow_err SHALL clear.
REQ-021 Latency SHALL be: valid asserts STABLE_CYCLES+1 edges after the completing digit's pattern first appears at the ports.
REQ-022 value, error and digit_err SHALL hold between frames.
REQ-023 cnt SHALL be 8 bits and saturate, with no wrap.

Reset
REQ-024 While reset is high at an edge, the block SHALL set state=WAIT, cnt=0, captured=0, shadow=0, shadow_err=0, value=0, valid=0, error=0, digit_err=0 and input registers=0.
REQ-025 Reset mid-dwell or mid-frame SHALL discard partial captures, and the first frame after reset SHALL require every digit anew.

Structure
REQ-026 Package seg7_pkg SHALL hold the 16-entry pattern constant table and the FSM state enum, shared with the hex encoder.
REQ-027 The block SHALL use one sub-module, seg7_pattern_decode, combinational: pattern in, nibble and hit out.

Verification
REQ-028 The bench SHALL scan 0x1A3F with NDIGITS=4 and STABLE_CYCLES=4, 8 cycles per digit, digits 0..3 in order, and check exactly one valid pulse with value=16'h1A3F and error=0.
REQ-029 The bench SHALL present digit 0 pattern 7E for only 3 cycles, then digit_sel=0, and check no capture and no valid.
REQ-030 The bench SHALL scan with digit 2 pattern 00 and check valid, digit_err=4'b0100, error=1 and nibble 2=0.
REQ-031 The bench SHALL assert digit_sel=4'b0011 for 20 cycles and check WAIT is held with no capture, then run a clean scan of 0xBEEF and check value=16'hBEEF.
REQ-032 The bench SHALL capture digits 0..1, assert reset for 1 cycle, then scan 0x0042 and check that valid occurs only after all 4 digits are re-captured, with value=16'h0042.
REQ-033 The bench SHALL re-present digit 1 first as 30 and then as 6D within one frame and check that nibble 1=2.
